// File: rtl/soc_system_btn_ctrl.sv
// Two-button debouncer with timestamped press-event FIFO behind an Avalon-MM slave.
// Register map: 0 STATUS, 1 EVENT (pop-on-read), 2 IRQ_EN, 3 CTRL (OVF clear / flush).
module soc_system_btn_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    input  logic [1:0]  in_port,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = 18;
    localparam logic [15:0]      DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [1:0]       sync1_q, sync2_q, stable_q, stable_d;
    logic [1:0][15:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]       press;
    logic [15:0]      ts_q;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             irq_en_q, irq_en_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q;
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0] head;

    logic rd_stb, wr_stb, ctrl_wr, flush, empty, full, pop, push, overflow;
    logic unused_wdata;

    assign unused_wdata = ^writedata[31:1];
    assign rd_stb   = chipselect & ~read_n;
    assign wr_stb   = chipselect & ~write_n;
    assign ctrl_wr  = wr_stb & (address == 2'd3);
    assign flush    = ctrl_wr & writedata[0];
    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign head     = mem_q[rd_ptr_q];
    // Flush overrides both pop and push; a pop frees the slot a same-cycle push needs.
    assign pop      = rd_stb & (address == 2'd1) & ~empty & ~flush;
    assign push     = (|press) & ~flush & (~full | pop);
    assign overflow = (|press) & ~flush & full & ~pop;

    // Per-button debounce: accept the synced level after DEBOUNCE_CYCLES mismatched cycles.
    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = deb_cnt_q;
        press     = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                stable_d[i]  = sync2_q[i];
                deb_cnt_d[i] = '0;
                press[i]     = ~sync2_q[i];
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + 16'd1;
            end
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        irq_en_d   = irq_en_q;
        readdata_d = readdata_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
        if (ctrl_wr)  ovf_d = 1'b0;
        if (overflow) ovf_d = 1'b1;
        if (wr_stb && address == 2'd2) irq_en_d = writedata[0];
        if (rd_stb) begin
            case (address)
                2'd0:    readdata_d = {20'b0, 4'(count_q), 1'b0, ovf_q, full, empty, 2'b0, stable_q};
                2'd1:    readdata_d = empty ? 32'h0 : {1'b1, 13'b0, head};
                2'd2:    readdata_d = {31'b0, irq_en_q};
                default: readdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            stable_q   <= 2'b11;
            deb_cnt_q  <= '0;
            ts_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            deb_cnt_q  <= deb_cnt_d;
            ts_q       <= ts_q + 16'd1;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            irq_en_q   <= irq_en_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_en_q & ~empty;
        end
    end

    // Entry storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {press, ts_q};
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_soc_system_btn_ctrl.sv
// Self-checking bench: register vector table, directed corner sequences, and
// randomized traffic checked every cycle against a queue-based reference model.
module tb_soc_system_btn_ctrl;

    localparam int DEB   = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect, read_n, write_n;
    logic [31:0] writedata;
    logic [1:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    always #5 clk = ~clk;

    soc_system_btn_ctrl #(.DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .in_port(in_port), .readdata(readdata), .irq(irq)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [1:0]  m_s1, m_s2, m_stable;
    int          m_run [2];
    int          m_cyc;
    logic [17:0] m_q [$];
    logic        m_ovf, m_irq_en, m_irq;
    logic [31:0] m_rd;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        int n = m_q.size();
        return {20'b0, 4'(n), 1'b0, m_ovf, (n == DEPTH), (n == 0), 2'b0, m_stable};
    endfunction

    // Advance the model by one clock using the inputs currently presented.
    task automatic model_step();
        logic       rd, wr;
        logic [1:0] mask, nstable;
        if (reset) begin
            m_s1 = 2'b11; m_s2 = 2'b11; m_stable = 2'b11;
            m_run[0] = 0; m_run[1] = 0; m_cyc = 0;
            m_q.delete(); m_ovf = 0; m_irq_en = 0; m_irq = 0; m_rd = 32'h0;
            return;
        end
        rd = chipselect & ~read_n;
        wr = chipselect & ~write_n;
        mask = 2'b00;
        nstable = m_stable;
        for (int i = 0; i < 2; i++) begin
            if (m_s2[i] != m_stable[i]) begin
                if (m_run[i] == DEB - 1) begin
                    nstable[i] = m_s2[i];
                    m_run[i] = 0;
                    if (!m_s2[i]) mask[i] = 1'b1;
                end else begin
                    m_run[i] = m_run[i] + 1;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_irq = m_irq_en && (m_q.size() != 0);
        if (rd) begin
            case (address)
                2'd0:    m_rd = m_status();
                2'd1:    m_rd = (m_q.size() != 0) ? {1'b1, 13'b0, m_q[0]} : 32'h0;
                2'd2:    m_rd = {31'b0, m_irq_en};
                default: m_rd = 32'h0;
            endcase
        end
        if (wr && address == 2'd3 && writedata[0]) begin
            m_q.delete();
            m_ovf = 0;
        end else begin
            if (rd && address == 2'd1 && m_q.size() != 0) void'(m_q.pop_front());
            if (wr && address == 2'd3) m_ovf = 0;
            if (mask != 2'b00) begin
                if (m_q.size() < DEPTH) m_q.push_back({mask, 16'(m_cyc)});
                else m_ovf = 1;
            end
        end
        if (wr && address == 2'd2) m_irq_en = writedata[0];
        m_stable = nstable;
        m_s2 = m_s1;
        m_s1 = in_port;
        m_cyc = m_cyc + 1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("cyc_readdata", readdata, m_rd);
        check("cyc_irq", {31'b0, irq}, {31'b0, m_irq});
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        tick();
        chipselect = 1'b0; read_n = 1'b1;
        d = readdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic press(input int b);
        in_port[b] = 1'b0;
        idle(8);
        in_port[b] = 1'b1;
        idle(8);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        reset = 1'b1; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        address = 2'd0; writedata = 32'h0; in_port = 2'b11;

        vecs[0]  = '{1'b0, 2'd0, 32'h0,        32'h0000_0013};
        vecs[1]  = '{1'b1, 2'd2, 32'hFFFF_FFFF, 32'h0};
        vecs[2]  = '{1'b0, 2'd2, 32'h0,        32'h0000_0001};
        vecs[3]  = '{1'b0, 2'd3, 32'h0,        32'h0};
        vecs[4]  = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0};
        vecs[5]  = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0};
        vecs[6]  = '{1'b0, 2'd0, 32'h0,        32'h0000_0013};
        vecs[7]  = '{1'b0, 2'd1, 32'h0,        32'h0};
        vecs[8]  = '{1'b1, 2'd2, 32'h2,        32'h0};
        vecs[9]  = '{1'b0, 2'd2, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 2'd3, 32'h0,        32'h0};

        do_reset();
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].data);
            end else begin
                bus_read(vecs[i].addr, d);
                check($sformatf("vec%0d", i), d, vecs[i].exp);
            end
            check($sformatf("vec%0d_irq", i), {31'b0, irq}, 32'h0);
        end

        // Short glitch rejected, long press accepted with its timestamp.
        do_reset();
        in_port = 2'b10; idle(3);
        in_port = 2'b11; idle(10);
        in_port = 2'b10; idle(10);
        in_port = 2'b11; idle(10);
        bus_read(2'd0, d);
        check("deb_status", d, 32'h0000_0103);
        bus_read(2'd1, d);
        check("deb_event", d, 32'h8001_0012);

        // Simultaneous presses share one entry.
        in_port = 2'b00; idle(8);
        in_port = 2'b11; idle(8);
        bus_read(2'd1, d);
        check("both_mask", {16'b0, d[31:16]}, 32'h0000_8003);
        bus_read(2'd1, d);
        check("both_empty", d, 32'h0);

        // Interrupt follows enable and FIFO occupancy.
        bus_write(2'd2, 32'h1);
        press(0);
        check("irq_set", {31'b0, irq}, 32'h1);
        bus_read(2'd1, d);
        check("irq_hold", {31'b0, irq}, 32'h1);
        idle(1);
        check("irq_clr", {31'b0, irq}, 32'h0);
        press(1);
        check("irq_set2", {31'b0, irq}, 32'h1);
        bus_write(2'd2, 32'h0);
        idle(1);
        check("irq_dis", {31'b0, irq}, 32'h0);
        bus_write(2'd3, 32'h1);

        // Overflow on the ninth press, cleared by any CTRL write.
        for (int i = 0; i < 9; i++) press(i % 2);
        bus_read(2'd0, d);
        check("ovf_status", d, 32'h0000_0863);
        bus_write(2'd3, 32'h0);
        bus_read(2'd0, d);
        check("ovf_cleared", d, 32'h0000_0823);

        // Full FIFO: press on the read cycle fits; press on the flush cycle is discarded.
        in_port = 2'b10; idle(5);
        bus_read(2'd1, d);
        in_port = 2'b11; idle(8);
        bus_read(2'd0, d);
        check("full_pushpop", d, 32'h0000_0823);
        in_port = 2'b10; idle(5);
        bus_write(2'd3, 32'h1);
        in_port = 2'b11; idle(8);
        bus_read(2'd0, d);
        check("flush_wins", d, 32'h0000_0013);

        // Reset mid-debounce with a nonempty FIFO discards everything.
        bus_write(2'd2, 32'h1);
        press(0);
        in_port = 2'b10; idle(3);
        reset = 1'b1; in_port = 2'b11; idle(2); reset = 1'b0;
        check("rst_irq", {31'b0, irq}, 32'h0);
        idle(10);
        bus_read(2'd0, d);
        check("rst_status", d, 32'h0000_0013);
        bus_read(2'd2, d);
        check("rst_irq_en", d, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int op;
            if ($urandom_range(9, 0) == 0) begin
                int b = int'($urandom_range(1, 0));
                in_port[b] = ~in_port[b];
            end
            op = int'($urandom_range(15, 0));
            if (op < 4) begin
                chipselect = 1'b1; read_n = 1'b0; address = 2'($urandom_range(3, 0));
                idle(1 + int'($urandom_range(1, 0)));
                chipselect = 1'b0; read_n = 1'b1;
            end else if (op == 4) begin
                bus_write(2'($urandom_range(2, 0)), $urandom());
            end else if (op == 5) begin
                bus_write(2'd3, {$urandom_range(1, 0) == 0 ? 31'h0 : 31'h1, ($urandom_range(3, 0) == 0)});
            end else begin
                idle(1);
            end
        end
        chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1; in_port = 2'b11;

        // Timestamp wrap: accept lands on cycle 65539 after reset.
        do_reset();
        idle(65534);
        in_port = 2'b10; idle(7);
        in_port = 2'b11; idle(8);
        bus_read(2'd1, d);
        check("ts_wrap", d, 32'h8001_0003);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_system_btn_ctrl.md
SOC_SYSTEM_BTN_CTRL -- requirements
Module: soc_system_btn_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000, sets the stable-input cycles needed to accept a level change (1 ms at 50 MHz); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8, sets the event FIFO entries; power of two, 2..16.
REQ-003 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 address  in  2  Avalon-MM word address.
REQ-006 chipselect  in  1  slave select.
REQ-007 read_n  in  1  active-low read strobe, qualified by chipselect.
REQ-008 write_n  in  1  active-low write strobe, qualified by chipselect.
REQ-009 writedata  in  32  write data.
REQ-010 in_port  in  2  raw button levels, asynchronous, active-low (pressed = 0).
REQ-011 readdata  out  32  registered read data.
REQ-012 irq  out  1  registered level interrupt.

Function
REQ-013 in_port SHALL pass through a 2-FF synchronizer before any other use.
REQ-014 Per button: 16-bit debounce counter clears when synced input equals stable level; otherwise increments; at DEBOUNCE_CYCLES-1 the stable level takes the synced value and the counter clears.
REQ-015 A press event SHALL be a stable-level 1->0 transition; releases generate no event.
REQ-016 A free-running 16-bit timestamp SHALL increment every cycle and wrap 0xFFFF->0x0000.
REQ-017 Each cycle with at least one press SHALL push one FIFO entry {mask[1:0], timestamp[15:0]}; simultaneous presses share one entry (mask=2'b11).
REQ-018 Push when full, with no pop that cycle, SHALL drop the entry and set sticky OVF.
REQ-019 Push and pop in the same cycle when full SHALL both occur; OVF unchanged, count unchanged.
REQ-020 Map: addr0 STATUS (RO) = {20'b0, count[3:0] at [11:8], 1'b0, OVF[6], full[5], empty[4], 2'b0, stable[1:0]}.
REQ-021 addr1 EVENT (RO, pop-on-read): nonempty -> {1'b1 at [31], 13'b0, mask[17:16], timestamp[15:0]} and head popped; empty -> 0, no pop, no error.
REQ-022 addr2 IRQ_EN (RW): bit0 enable; other bits read 0.
REQ-023 addr3 CTRL (WO, reads 0): any write clears OVF; writedata[0]=1 flushes FIFO (count=0).
REQ-024 Flush coinciding with a push SHALL win: FIFO empty afterwards, event discarded, OVF not set.
REQ-025 readdata SHALL update the cycle after chipselect & ~read_n (1-cycle latency); otherwise it holds its value.
REQ-026 Pop SHALL occur once per read-strobe cycle; a two-cycle strobe pops twice.
REQ-027 irq SHALL be registered IRQ_EN & ~empty, valid one cycle after the state change.
REQ-028 Writes to addr0/addr1 and reads of addr3 SHALL have no side effect.

Reset
REQ-029 On reset: readdata=0, irq=0, IRQ_EN=0, OVF=0, FIFO empty, timestamp=0, counters=0, synchronizer and stable levels=2'b11.
REQ-030 Reset asserted mid-debounce or with a nonempty FIFO SHALL discard all state; no event SHALL be generated by reset release while inputs are held high.

Verification
REQ-031 DEBOUNCE_CYCLES=4: in_port[0] low for 3 cycles then high -> no event; low for 10 cycles -> one entry, mask=01, STATUS count=1.
REQ-032 Both buttons go low on the same cycle, held -> single entry mask=11; EVENT read returns bit31=1, [17:16]=11; next read returns 0.
REQ-033 FIFO_DEPTH=8: 9 presses with no reads -> count=8, full=1, OVF=1; write addr3 data 0 -> OVF=0, count=8.
REQ-034 IRQ_EN=1, one press -> irq=1 one cycle after push; read EVENT -> irq=0 one cycle after pop; IRQ_EN=0 with nonempty FIFO -> irq=0.
REQ-035 FIFO full, press coincides with EVENT read -> count stays 8, OVF=0; press coincides with flush write -> count=0, OVF=0.
REQ-036 Timestamp: reset released, press accepted at cycle N -> entry timestamp = N mod 65536; run past 65536 cycles and verify the wrap value.
